// File: rtl/imm_decode_pipe.sv
// Registered RISC-V immediate/format decode stage with a one-entry skid buffer.
// Defining IMM_DECODE_CSR_EN adds CSR immediate decode (fmt Z and CSR address) for SYSTEM opcodes.
module imm_decode_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] target
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_RSVD = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } entry_t;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_OP        = 7'b0110011;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_OP_32     = 7'b0111011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  localparam bit IS_RV64 = (XLEN == 64);

  logic [6:0]      opcode;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic            csr_zext;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  entry_t          dec_entry;

  assign opcode = instr[6:0];

  always_comb begin
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    csr_zext    = 1'b0;
    case (opcode)
      OP_LOAD, OP_OP_IMM, OP_JALR: dec_fmt = FMT_I;
      OP_OP_IMM_32: begin
        if (IS_RV64) dec_fmt = FMT_I;
        else         dec_illegal = 1'b1;
      end
      OP_STORE:            dec_fmt = FMT_S;
      OP_BRANCH:           dec_fmt = FMT_B;
      OP_JAL:              dec_fmt = FMT_J;
      OP_LUI, OP_AUIPC:    dec_fmt = FMT_U;
      OP_OP, OP_MISC_MEM:  dec_fmt = FMT_NONE;
      OP_OP_32: begin
        if (!IS_RV64) dec_illegal = 1'b1;
      end
      OP_SYSTEM: begin
`ifdef IMM_DECODE_CSR_EN
        if (instr[14] && (instr[13:12] != 2'b00)) begin
          dec_fmt = FMT_Z;
        end else if (!instr[14] && (instr[13:12] != 2'b00)) begin
          dec_fmt  = FMT_I;
          csr_zext = 1'b1;
        end
`else
        dec_fmt = FMT_NONE;
`endif
      end
      default: dec_illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) dec_illegal = 1'b1;
    if (dec_illegal) dec_fmt = FMT_NONE;
  end

  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FMT_I: dec_imm = csr_zext ? XLEN'(instr[31:20]) : XLEN'($signed(instr[31:20]));
      FMT_S: dec_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B: dec_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_U: dec_imm = XLEN'($signed({instr[31:12], 12'b0}));
      FMT_J: dec_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      FMT_Z: dec_imm = XLEN'(instr[19:15]);
      default: dec_imm = '0;
    endcase
  end

  // JALR falls through to pc+4: its real target needs rs1, resolved later in execute.
  always_comb begin
    dec_target = pc + XLEN'(4);
    if (!dec_illegal && (dec_fmt == FMT_B || dec_fmt == FMT_J || opcode == OP_AUIPC))
      dec_target = pc + dec_imm;
  end

  always_comb begin
    dec_entry.imm     = dec_imm;
    dec_entry.fmt     = dec_fmt;
    dec_entry.illegal = dec_illegal;
    dec_entry.pc      = pc;
    dec_entry.target  = dec_target;
  end

  state_e state, state_next;
  entry_t out_q, skid_q;
  logic   in_fire, out_fire;
  logic   load_out_dec, load_out_skid, load_skid;

  // in_ready depends only on registered state so no combinational path runs from out_ready.
  assign in_ready  = (state != TWO) && !rst;
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    load_out_dec  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_next   = ONE;
          load_out_dec = 1'b1;
        end
      end
      ONE: begin
        case ({in_fire, out_fire})
          2'b10: begin
            state_next = TWO;
            load_skid  = 1'b1;
          end
          2'b01: state_next = EMPTY;
          2'b11: load_out_dec = 1'b1;
          default: state_next = ONE;
        endcase
      end
      TWO: begin
        if (out_fire) begin
          state_next    = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_dec)       out_q <= dec_entry;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= dec_entry;
    end
  end

  assign imm     = out_q.imm;
  assign fmt     = out_q.fmt;
  assign illegal = out_q.illegal;
  assign pc_out  = out_q.pc;
  assign target  = out_q.target;

endmodule

// File: doc/imm_decode_pipe.md
# imm_decode_pipe

Registered, parametrised immediate-generation stage for the single-cycle-to-pipelined RISC-V datapath. It accepts a 32-bit instruction and its PC over a valid/ready handshake and decodes the opcode into a format code and an XLEN-wide immediate. It also computes the PC-relative target and flags illegal encodings. One output register plus a one-entry skid buffer give full throughput under backpressure; the block sits between instruction fetch and the register-read/execute stage.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instr/pc valid.
- in_ready  output  1  stage can accept input.
- instr  input  32  raw instruction.
- pc  input  XLEN  address of instr.
- out_valid  output  1  output fields valid.
- out_ready  input  1  downstream accepts output.
- imm  output  XLEN  decoded immediate.
- fmt  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR uimm), 7 reserved.
- illegal  output  1  unrecognised encoding.
- pc_out  output  XLEN  pc passed through.
- target  output  XLEN  branch/jump/auipc target or pc+4.

## Operation
- Decode, sign-extend from instr[31] to XLEN:
  - I-type for opcodes 0000011, 0010011, 1100111, and 0011011 when XLEN=64: imm=instr[31:20].
  - S-type for 0100011: {instr[31:25],instr[11:7]}.
  - B-type for 1100011: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - J-type for 1101111: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - U-type for 0110111 and 0010111: {instr[31:12],12'b0}, sign-extended on XLEN=64.
- R-type (0110011, and 0111011 when XLEN=64), FENCE (0001111) and SYSTEM (1110011, without the macro): fmt=NONE, imm=0, illegal=0.
- Illegal encodings:
  - Condition: instr[1:0]!=2'b11, or an opcode not listed above (0011011/0111011 are illegal when XLEN=32).
  - Response: illegal=1, fmt=NONE, imm=0, target=pc+4.
- target:
  - fmt B, fmt J, or opcode 0010111: pc+imm.
  - Otherwise: pc+4.
  - Addition is modulo 2^XLEN; wrap-around is not flagged.
- JALR target is not computed here because it needs rs1; JALR takes target=pc+4.

## Timing
- Occupancy state machine:
  - EMPTY: out_valid=0.
  - ONE: output register full, skid empty.
  - TWO: output register and skid both full.
- in_ready = !skid_full && !rst. It depends only on registered state, not on out_ready (no combinational path in->out).
- Transfers happen on a rising edge: input when in_valid&&in_ready; output when out_valid&&out_ready.
- Latency: an input accepted at edge N is presented at out_valid after edge N (1 cycle) when the stage is EMPTY, or when in ONE with a simultaneous output transfer.
- Transitions:
  - EMPTY + input -> ONE.
  - ONE + input, no output transfer -> TWO (input decoded into skid).
  - ONE + output transfer, no input -> EMPTY.
  - ONE + both -> ONE (output reg loads new input).
  - TWO + output transfer -> ONE (skid moves to output reg). No input is accepted in TWO.
- While out_valid=1 and out_ready=0, all output fields hold stable.
- Order is preserved; no loss or duplication.
- Reset:
  - Output and skid state: out_valid=0, skid empty, imm/fmt/illegal/pc_out/target=0.
  - in_ready: 0 while rst is high, 1 on the first cycle after.
  - Reset mid-transfer discards both held entries.

## Configuration
- IMM_DECODE_CSR_EN defined:
  - SYSTEM opcode with funct3[2]=1 (csrrwi/csrrsi/csrrci): fmt=Z, imm=zero-extended instr[19:15].
  - SYSTEM with funct3 of 001, 010 or 011 (csrrw/csrrs/csrrc): fmt=I, imm=zero-extended instr[31:20] (CSR address).
  - funct3=000 and funct3=100: fmt=NONE, imm=0.
- IMM_DECODE_CSR_EN undefined: all SYSTEM encodings give fmt=NONE, imm=0, illegal=0. fmt code 6 is never produced.

## Test plan
- lw x1,-4(x2) (0xFFC12083), out_ready=1:
  - XLEN=32: one cycle later imm=0xFFFFFFFC, fmt=1.
  - XLEN=64: imm=0xFFFFFFFFFFFFFFFC.
- sw x1,-4(x2) (0xFE112E23) -> imm=0xFFFFFFFC, fmt=2. lui x5,0x12345 (0x123452B7) -> imm=0x12345000, fmt=4, target=pc+4.
- beq x0,x0,-8 (0xFE000CE3), pc=0x100 -> imm=0xFFFFFFF8, fmt=3, target=0xF8. jal x1,2048 (0x001000EF), pc=0x1000 -> imm=0x800, target=0x1800.
- instr=0x00000000 -> illegal=1, fmt=0, imm=0. Opcode 0011011 at XLEN=32 -> illegal=1.
- Backpressure: out_ready=0 with three back-to-back valid inputs A,B,C:
  - A and B are accepted; in_ready falls after B; C is held.
  - Raise out_ready -> outputs A,B,C in order, none dropped or repeated.
  - Assert rst in state TWO -> out_valid=0 next cycle.
- csrrwi x0,0x300,5 (0x3002D073):
  - With IMM_DECODE_CSR_EN: imm=5, fmt=6.
  - Without it: imm=0, fmt=0, illegal=0.
